// File: rtl/control_sequencer.sv
// Microcode T-state sequencer and control-line decoder for the 4-bit-opcode datapath.
// Two fetch steps, up to three execute steps, optional early return to T0, sticky halt.
module control_sequencer #(
  parameter int STEPS      = 5,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic       carry_flag,
  input  logic       zero_flag,
  output logic [2:0] step,
  output logic       halted,
  output logic       HLT,
  output logic       MI,
  output logic       RI,
  output logic       RO,
  output logic       IO,
  output logic       II,
  output logic       AI,
  output logic       AO,
  output logic       EO,
  output logic       SU,
  output logic       BI,
  output logic       OI,
  output logic       CE,
  output logic       CO,
  output logic       J,
  output logic       FI
);

  localparam logic [15:0] C_HLT = 16'h8000, C_MI = 16'h4000, C_RI = 16'h2000, C_RO = 16'h1000;
  localparam logic [15:0] C_IO  = 16'h0800, C_II = 16'h0400, C_AI = 16'h0200, C_AO = 16'h0100;
  localparam logic [15:0] C_EO  = 16'h0080, C_SU = 16'h0040, C_BI = 16'h0020, C_OI = 16'h0010;
  localparam logic [15:0] C_CE  = 16'h0008, C_CO = 16'h0004, C_J  = 16'h0002, C_FI = 16'h0001;
  localparam logic [2:0]  LAST  = 3'(STEPS - 1);

  // state | meaning
  // T0    | fetch: PC onto bus, load MAR
  // T1    | fetch: RAM into IR, increment PC
  // T2-T4 | execute steps from the opcode table
  // T5-T7 | only reachable when STEPS > 5; decode to no controls
  typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5, T6, T7} t_state;

  t_state      r_step, w_step_nxt;
  logic        r_halted, w_halted_nxt;
  logic [2:0]  w_step_plus;
  logic [15:0] w_word_cur, w_word_nxt, w_ctl;

  function automatic logic [15:0] decode(input logic [2:0] s, input logic [3:0] op,
                                         input logic c, input logic z);
    logic [15:0] w;
    w = '0;
    if (s <= LAST) begin
      case (s)
        3'd0: w = C_CO | C_MI;
        3'd1: w = C_RO | C_II | C_CE;
        3'd2: begin
          case (op)
            4'b0001, 4'b0010, 4'b0011, 4'b0100: w = C_IO | C_MI;
            4'b0101: w = C_IO | C_AI;
            4'b0110: w = C_IO | C_J;
            4'b0111: w = c ? (C_IO | C_J) : '0;
            4'b1000: w = z ? (C_IO | C_J) : '0;
            4'b1110: w = C_AO | C_OI;
            4'b1111: w = C_HLT;
            default: w = '0;
          endcase
        end
        3'd3: begin
          case (op)
            4'b0001: w = C_RO | C_AI;
            4'b0010, 4'b0011: w = C_RO | C_BI;
            4'b0100: w = C_AO | C_RI;
            default: w = '0;
          endcase
        end
        3'd4: begin
          case (op)
            4'b0010: w = C_EO | C_AI | C_FI;
            4'b0011: w = C_EO | C_AI | C_SU | C_FI;
            default: w = '0;
          endcase
        end
        default: w = '0;
      endcase
    end
    return w;
  endfunction

  assign w_step_plus = r_step + 3'd1;
  assign w_word_cur  = decode(r_step, opcode, carry_flag, zero_flag);
  assign w_word_nxt  = decode(w_step_plus, opcode, carry_flag, zero_flag);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_step   <= T0;
      r_halted <= 1'b0;
    end else begin
      r_step   <= w_step_nxt;
      r_halted <= w_halted_nxt;
    end
  end

  // Halt wins over wrap so the step freezes at T2 even when STEPS == 3.
  always_comb begin
    w_step_nxt   = r_step;
    w_halted_nxt = r_halted;
    if (!r_halted) begin
      if (r_step == T2 && opcode == 4'b1111)
        w_halted_nxt = 1'b1;
      else if (r_step == LAST)
        w_step_nxt = T0;
      else if (EARLY_EXIT && r_step >= T2 && w_word_nxt == '0)
        w_step_nxt = T0;
      else
        w_step_nxt = t_state'(w_step_plus);
    end
  end

  always_comb begin
    w_ctl = w_word_cur;
    if (rst)
      w_ctl = '0;
    else if (r_halted)
      w_ctl = C_HLT;
  end

  assign {HLT, MI, RI, RO, IO, II, AI, AO, EO, SU, BI, OI, CE, CO, J, FI} = w_ctl;
  assign step   = r_step;
  assign halted = r_halted;

endmodule
